// File: rtl/kart_controller.sv
// kart_controller: per-frame kart state engine. Each frame it looks up the
// track/obstacle tile under the kart, applies the driver inputs to speed,
// heading and lap count, then moves the kart in quarter-pixel units.
//
// Frame sequence: IDLE -> LOOKUP -> WAIT -> SAMPLE -> UPDATE -> MOVE -> IDLE.
// A tick is only accepted in IDLE; ticks in any other state are dropped.
// update_done_out is high for the single cycle after the new position is
// registered, and the position then holds until the next frame's MOVE.
module kart_controller #(
  parameter int MAX_SPEED       = 8,
  parameter int SAND_MAX_SPEED  = 3,
  parameter int ACCEL           = 1,
  parameter int TURN_FRAMES     = 4,
  parameter int OIL_SPIN_FRAMES = 30,
  parameter int START_X         = 1024,
  parameter int START_Y         = 1024,
  parameter int START_HEADING   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_tick_in,
  input  logic        btn_accel_in,
  input  logic        btn_brake_in,
  input  logic        btn_left_in,
  input  logic        btn_right_in,
  output logic [7:0]  tile_addr_out,
  input  logic [3:0]  tile_type_in,
  input  logic [3:0]  obstacle_type_in,
  output logic [10:0] player_x_out,
  output logic [10:0] player_y_out,
  output logic [2:0]  heading_out,
  output logic [3:0]  speed_out,
  output logic [3:0]  lap_count_out,
  output logic        update_done_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_MOVE   = 3'd5;

  localparam logic [5:0]  ROAD_LIM    = 6'(MAX_SPEED);
  localparam logic [5:0]  SAND_LIM    = 6'(SAND_MAX_SPEED);
  localparam logic [5:0]  ACCEL_STEP  = 6'(ACCEL);
  localparam logic [7:0]  TURN_RELOAD = 8'(TURN_FRAMES - 1);
  localparam logic [5:0]  SPIN_LOAD   = 6'(OIL_SPIN_FRAMES);
  localparam logic [10:0] X_RESET     = 11'(START_X);
  localparam logic [10:0] Y_RESET     = 11'(START_Y);
  localparam logic [2:0]  H_RESET     = 3'(START_HEADING);

  localparam logic [3:0] TILE_SAND   = 4'd1;
  localparam logic [3:0] OBST_FINISH = 4'd5;
  localparam logic [3:0] OBST_OIL    = 4'd6;

  logic [2:0] state;
  logic [3:0] tile;
  logic [3:0] obstacle;
  logic [3:0] prev_obstacle;
  logic [5:0] spin_cnt;
  logic [7:0] turn_cd;

  logic [3:0] next_speed;
  logic [2:0] next_heading;
  logic [5:0] next_spin;
  logic [7:0] next_cd;
  logic [3:0] next_lap;
  logic [5:0] limit;
  logic [5:0] speed_wide;
  logic [5:0] raw_speed;

  logic        x_pos, x_neg, y_pos, y_neg;
  logic [12:0] step;
  logic [12:0] x_wide, y_wide;
  logic [10:0] next_x, next_y;

  // Frame update rules: spinning beats oil entry beats normal driving.
  always_comb begin
    limit        = (tile == TILE_SAND) ? SAND_LIM : ROAD_LIM;
    speed_wide   = {2'b00, speed_out};
    raw_speed    = speed_wide;
    next_speed   = speed_out;
    next_heading = heading_out;
    next_spin    = spin_cnt;
    next_cd      = turn_cd;
    if (spin_cnt != 6'd0) begin
      next_speed   = 4'd0;
      next_heading = heading_out + 3'd1;
      next_spin    = spin_cnt - 6'd1;
    end else if (obstacle == OBST_OIL && prev_obstacle != OBST_OIL) begin
      next_spin  = SPIN_LOAD;
      next_speed = 4'd0;
    end else begin
      if (btn_brake_in) begin
        raw_speed = (speed_wide >= 6'd2) ? speed_wide - 6'd2 : 6'd0;
      end else if (btn_accel_in) begin
        raw_speed = speed_wide + ACCEL_STEP;
      end else begin
        raw_speed = (speed_wide != 6'd0) ? speed_wide - 6'd1 : 6'd0;
      end
      // Also pulls a fast kart down to the sand cap on the first sand frame.
      if (raw_speed > limit) raw_speed = limit;
      next_speed = raw_speed[3:0];
      if ((btn_left_in ^ btn_right_in) && turn_cd == 8'd0) begin
        next_heading = btn_left_in ? heading_out - 3'd1 : heading_out + 3'd1;
        next_cd      = TURN_RELOAD;
      end else if (turn_cd != 8'd0) begin
        next_cd = turn_cd - 8'd1;
      end
    end
    next_lap = lap_count_out;
    if (obstacle == OBST_FINISH && prev_obstacle != OBST_FINISH &&
        lap_count_out != 4'd15) begin
      next_lap = lap_count_out + 4'd1;
    end
  end

  // Position integration along the heading vector, saturated to the track.
  always_comb begin
    x_pos = 1'b0;
    x_neg = 1'b0;
    y_pos = 1'b0;
    y_neg = 1'b0;
    case (heading_out)
      3'd0: y_neg = 1'b1;
      3'd1: begin x_pos = 1'b1; y_neg = 1'b1; end
      3'd2: x_pos = 1'b1;
      3'd3: begin x_pos = 1'b1; y_pos = 1'b1; end
      3'd4: y_pos = 1'b1;
      3'd5: begin x_neg = 1'b1; y_pos = 1'b1; end
      3'd6: x_neg = 1'b1;
      default: begin x_neg = 1'b1; y_neg = 1'b1; end
    endcase
    step   = {9'd0, speed_out};
    x_wide = {2'b00, player_x_out};
    y_wide = {2'b00, player_y_out};
    if (x_pos) x_wide = x_wide + step;
    else if (x_neg) x_wide = x_wide - step;
    if (y_pos) y_wide = y_wide + step;
    else if (y_neg) y_wide = y_wide - step;
    // Bit 12 set means the result went negative; bit 11 means past 2047.
    if (x_wide[12]) next_x = 11'd0;
    else if (x_wide[11]) next_x = 11'd2047;
    else next_x = x_wide[10:0];
    if (y_wide[12]) next_y = 11'd0;
    else if (y_wide[11]) next_y = 11'd2047;
    else next_y = y_wide[10:0];
  end

  // Frame sequencer and all kart state registers.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state           <= S_IDLE;
      tile            <= 4'd0;
      obstacle        <= 4'd0;
      prev_obstacle   <= 4'd0;
      spin_cnt        <= 6'd0;
      turn_cd         <= 8'd0;
      tile_addr_out   <= 8'd0;
      player_x_out    <= X_RESET;
      player_y_out    <= Y_RESET;
      heading_out     <= H_RESET;
      speed_out       <= 4'd0;
      lap_count_out   <= 4'd0;
      update_done_out <= 1'b0;
    end else begin
      update_done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_tick_in) begin
            tile_addr_out <= {player_y_out[10:7], player_x_out[10:7]};
            state         <= S_LOOKUP;
          end
        end
        S_LOOKUP: state <= S_WAIT;
        S_WAIT:   state <= S_SAMPLE;
        S_SAMPLE: begin
          tile     <= tile_type_in;
          obstacle <= obstacle_type_in;
          state    <= S_UPDATE;
        end
        S_UPDATE: begin
          speed_out     <= next_speed;
          heading_out   <= next_heading;
          spin_cnt      <= next_spin;
          turn_cd       <= next_cd;
          lap_count_out <= next_lap;
          prev_obstacle <= obstacle;
          state         <= S_MOVE;
        end
        S_MOVE: begin
          player_x_out    <= next_x;
          player_y_out    <= next_y;
          update_done_out <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kart_controller.sv
// tb_kart_controller: frame-level bench for kart_controller. A behavioural
// kart model produces the expected outputs of each frame when its tick is
// driven; they are queued and compared when update_done_out appears.
module tb_kart_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        frame_tick;
  logic        btn_accel, btn_brake, btn_left, btn_right;
  logic [7:0]  tile_addr;
  logic [3:0]  tile_type, obstacle_type;
  logic [10:0] player_x, player_y;
  logic [2:0]  heading;
  logic [3:0]  speed, lap_count;
  logic        update_done;

  kart_controller dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .frame_tick_in    (frame_tick),
    .btn_accel_in     (btn_accel),
    .btn_brake_in     (btn_brake),
    .btn_left_in      (btn_left),
    .btn_right_in     (btn_right),
    .tile_addr_out    (tile_addr),
    .tile_type_in     (tile_type),
    .obstacle_type_in (obstacle_type),
    .player_x_out     (player_x),
    .player_y_out     (player_y),
    .heading_out      (heading),
    .speed_out        (speed),
    .lap_count_out    (lap_count),
    .update_done_out  (update_done)
  );

  int checks = 0;
  int errors = 0;

  // {addr[40:33], x[32:22], y[21:11], heading[10:8], speed[7:4], lap[3:0]}
  logic [40:0] exp_q[$];

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_x, m_y, m_head, m_speed, m_lap, m_spin, m_cd, m_prev;
  int dx_t[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dy_t[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  function automatic int clamp11(input int v);
    if (v < 0) return 0;
    if (v > 2047) return 2047;
    return v;
  endfunction

  task automatic model_reset();
    m_x = 1024; m_y = 1024; m_head = 2; m_speed = 0;
    m_lap = 0; m_spin = 0; m_cd = 0; m_prev = 0;
  endtask

  task automatic model_push(input logic a, b, l, r, input int tile, obst);
    int lim, sp, addr;
    addr = (((m_y >> 7) & 15) << 4) | ((m_x >> 7) & 15);
    lim = (tile == 1) ? 3 : 8;
    if (m_spin != 0) begin
      m_speed = 0;
      m_head  = (m_head + 1) % 8;
      m_spin  = m_spin - 1;
    end else if (obst == 6 && m_prev != 6) begin
      m_spin  = 30;
      m_speed = 0;
    end else begin
      if (b) sp = (m_speed > 2) ? m_speed - 2 : 0;
      else if (a) sp = m_speed + 1;
      else sp = (m_speed > 1) ? m_speed - 1 : 0;
      if (sp > lim) sp = lim;
      m_speed = sp;
      if ((l != r) && m_cd == 0) begin
        m_head = l ? (m_head + 7) % 8 : (m_head + 1) % 8;
        m_cd   = 3;
      end else if (m_cd != 0) begin
        m_cd = m_cd - 1;
      end
    end
    if (obst == 5 && m_prev != 5 && m_lap < 15) m_lap = m_lap + 1;
    m_prev = obst;
    m_x = clamp11(m_x + dx_t[m_head] * m_speed);
    m_y = clamp11(m_y + dy_t[m_head] * m_speed);
    exp_q.push_back({8'(addr), 11'(m_x), 11'(m_y), 3'(m_head), 4'(m_speed), 4'(m_lap)});
  endtask

  task automatic compare_out(input logic [40:0] e);
    check_val("tile_addr", tile_addr, e[40:33]);
    check_val("x", player_x, e[32:22]);
    check_val("y", player_y, e[21:11]);
    check_val("heading", heading, e[10:8]);
    check_val("speed", speed, e[7:4]);
    check_val("lap", lap_count, e[3:0]);
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  task automatic do_frame(input logic a, b, l, r, input logic [3:0] tile, obst);
    logic [40:0] e;
    int cyc, old_x, early_speed, early_x;
    old_x = m_x;
    model_push(a, b, l, r, int'(tile), int'(obst));
    btn_accel = a; btn_brake = b; btn_left = l; btn_right = r;
    tile_type = tile; obstacle_type = obst;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    cyc = 1;
    early_speed = -1;
    early_x = -1;
    while (!update_done && cyc < 12) begin
      if (cyc == 5) begin
        early_speed = speed;
        early_x = player_x;
      end
      @(negedge clk);
      cyc++;
    end
    check_val("done_latency", cyc, 6);
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      if (update_done) begin
        compare_out(e);
        check_val("speed_early", early_speed, e[7:4]);
        check_val("x_held", early_x, old_x);
        @(negedge clk);
        check_val("done_width", update_done, 0);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    int turn_tbl[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    btn_accel = 0; btn_brake = 0; btn_left = 0; btn_right = 0;
    tile_type = 0; obstacle_type = 0;
    do_reset();

    check_val("rst_x", player_x, 1024);
    check_val("rst_y", player_y, 1024);
    check_val("rst_heading", heading, 2);
    check_val("rst_speed", speed, 0);
    check_val("rst_lap", lap_count, 0);
    check_val("rst_addr", tile_addr, 0);
    check_val("rst_done", update_done, 0);

    // Acceleration on road, heading east.
    for (int i = 1; i <= 10; i++) begin
      do_frame(1, 0, 0, 0, 0, 0);
      check_val("accel_speed", speed, (i < 8) ? i : 8);
    end
    // Each frame moves by its freshly updated speed: 1+2+...+8+8+8 = 52.
    check_val("accel_x", player_x, 1076);
    check_val("accel_y", player_y, 1024);

    // Sand clamp and return to road.
    do_frame(1, 0, 0, 0, 1, 0);
    check_val("sand_speed1", speed, 3);
    do_frame(1, 0, 0, 0, 1, 0);
    check_val("sand_speed2", speed, 3);
    do_frame(1, 0, 0, 0, 0, 0);
    check_val("road_speed1", speed, 4);
    do_frame(1, 0, 0, 0, 0, 0);
    check_val("road_speed2", speed, 5);
    do_frame(1, 0, 0, 0, 0, 0);
    check_val("pre_oil_speed", speed, 6);

    // Oil entry, 30 spin frames, then no retrigger while still on oil.
    do_frame(1, 0, 0, 0, 0, 6);
    check_val("oil_speed", speed, 0);
    check_val("oil_heading", heading, 2);
    for (int i = 1; i <= 30; i++) begin
      do_frame(1, 0, 1, 0, 0, 6);
      check_val("spin_speed", speed, 0);
      check_val("spin_heading", heading, (2 + i) % 8);
    end
    check_val("spin_end_heading", heading, 0);
    do_frame(1, 0, 0, 0, 0, 6);
    check_val("post_spin_speed", speed, 1);

    // Turn cooldown: right back to heading 2, let cooldown expire, then left.
    for (int i = 0; i < 5; i++) do_frame(0, 0, 0, 1, 0, 0);
    check_val("turn_right_heading", heading, 2);
    for (int i = 0; i < 4; i++) do_frame(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      do_frame(0, 0, 1, 0, 0, 0);
      check_val("turn_left_heading", heading, turn_tbl[i]);
    end
    for (int i = 0; i < 4; i++) begin
      do_frame(0, 0, 1, 1, 0, 0);
      check_val("both_heading", heading, 0);
    end
    do_frame(1, 1, 0, 0, 0, 0);
    check_val("brake_priority", speed, 0);

    // Laps: finish entry counts once per visit, saturating at 15.
    for (int i = 1; i <= 17; i++) begin
      do_frame(0, 0, 0, 0, 0, 5);
      check_val("lap_enter", lap_count, (i < 15) ? i : 15);
      do_frame(0, 0, 0, 0, 0, 5);
      check_val("lap_dwell", lap_count, (i < 15) ? i : 15);
      do_frame(0, 0, 0, 0, 0, 0);
    end

    // A second tick three cycles after the first is dropped.
    for (int i = 0; i < 3; i++) do_frame(1, 0, 0, 0, 0, 0);
    model_push(1, 0, 0, 0, 0, 0);
    frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (update_done) begin
        dones++;
        if (dones == 1 && exp_q.size() != 0) compare_out(exp_q.pop_front());
      end
      @(negedge clk);
    end
    check_val("ignored_tick_dones", dones, 1);

    // Reset sampled at E3 of a frame aborts it.
    frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (update_done) dones++;
      @(negedge clk);
    end
    check_val("abort_dones", dones, 0);
    check_val("abort_x", player_x, 1024);
    check_val("abort_y", player_y, 1024);
    check_val("abort_heading", heading, 2);
    check_val("abort_speed", speed, 0);
    check_val("abort_lap", lap_count, 0);
    check_val("abort_addr", tile_addr, 0);
    model_reset();
    exp_q.delete();

    // Boundary saturation: east wall, west wall, then the NW corner.
    for (int i = 0; i < 140; i++) do_frame(1, 0, 0, 0, 0, 0);
    check_val("east_wall_x", player_x, 2047);
    check_val("east_wall_y", player_y, 1024);
    for (int i = 0; i < 13; i++) do_frame(1, 0, 0, 1, 0, 0);
    check_val("face_west", heading, 6);
    for (int i = 0; i < 300; i++) do_frame(1, 0, 0, 0, 0, 0);
    check_val("west_wall_x", player_x, 0);
    do_frame(1, 0, 0, 1, 0, 0);
    check_val("face_nw", heading, 7);
    for (int i = 0; i < 300; i++) do_frame(1, 0, 0, 0, 0, 0);
    check_val("corner_x", player_x, 0);
    check_val("corner_y", player_y, 0);
    check_val("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the run must never hang.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
